// File: rtl/game_tick_pkg.sv
// Shared definitions for the snake game timebase: state encoding, default
// timing constants and the period/turbo helpers.
package game_tick_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam int DEF_BASE_PERIOD     = 50_000_000;
    localparam int DEF_LEVELS          = 4;
    localparam int DEF_FOODS_PER_LEVEL = 4;
    localparam int TURBO_SHIFT         = 2;
    localparam int MIN_PERIOD          = 2;

    // Each level halves the tick period.
    function automatic int period_of(input int base, input int lvl);
        return base >> lvl;
    endfunction

    function automatic int turbo_period(input int p);
        int q;
        q = p >> TURBO_SHIFT;
        return (q < MIN_PERIOD) ? MIN_PERIOD : q;
    endfunction

endpackage

// File: rtl/game_tick_scheduler_tick_counter.sv
// Loadable down-counter for the tick timebase; load wins over enable and
// zero reflects the registered count.
module tick_counter #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/game_tick_scheduler.sv
// Snake game tick scheduler: run/pause/over FSM, food-driven speed level and
// registered tick strobe. Define GAME_TICK_TURBO_EN to add the turbo input.
module game_tick_scheduler
    import game_tick_pkg::*;
#(
    parameter int CNT_W           = 28,
    parameter int BASE_PERIOD     = DEF_BASE_PERIOD,
    parameter int LEVELS          = DEF_LEVELS,
    parameter int FOODS_PER_LEVEL = DEF_FOODS_PER_LEVEL
) (
    input  logic                      clk,
    input  logic                      clear_b,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      food_eaten,
    input  logic                      game_over,
`ifdef GAME_TICK_TURBO_EN
    input  logic                      turbo,
`endif
    output logic                      tick,
    output logic [$clog2(LEVELS)-1:0] level,
    output logic [1:0]                state,
    output logic                      running
);

    localparam int LVL_W  = $clog2(LEVELS);
    localparam int FOOD_W = $clog2(FOODS_PER_LEVEL + 1);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(LEVELS - 1);
    localparam logic [FOOD_W-1:0] FOOD_LAST = FOOD_W'(FOODS_PER_LEVEL - 1);

    state_t            state_q, state_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [FOOD_W-1:0] food_q, food_d;
    logic              tick_q, tick_d;

    logic              start_load;
    logic              cnt_en;
    logic              cnt_load;
    logic              cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val;
    int                reload_period;

    // Period is taken from the level before any same-edge food increment.
    always_comb begin
        reload_period = period_of(BASE_PERIOD, int'(level_q));
`ifdef GAME_TICK_TURBO_EN
        if (turbo) begin
            reload_period = turbo_period(reload_period);
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        food_d     = food_q;
        start_load = 1'b0;
        cnt_en     = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d    = RUN;
                    level_d    = '0;
                    food_d     = '0;
                    start_load = 1'b1;
                end
            end
            RUN: begin
                if (game_over) begin
                    state_d = OVER;
                end else begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else begin
                        cnt_en = 1'b1;
                    end
                    if (food_eaten) begin
                        if (food_q == FOOD_LAST) begin
                            food_d = '0;
                            if (level_q != LVL_MAX) begin
                                level_d = level_q + 1'b1;
                            end
                        end else begin
                            food_d = food_q + 1'b1;
                        end
                    end
                end
            end
            PAUSED: begin
                // The resume edge counts, so an N-cycle pause costs exactly N.
                if (game_over) begin
                    state_d = OVER;
                end else if (!pause) begin
                    state_d = RUN;
                    cnt_en  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        tick_d       = cnt_en && cnt_zero;
        cnt_load     = start_load || tick_d;
        cnt_load_val = start_load ? CNT_W'(BASE_PERIOD - 1) : CNT_W'(reload_period - 1);
    end

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk      (clk),
        .clear_b  (clear_b),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state_q <= IDLE;
            level_q <= '0;
            food_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            food_q  <= food_d;
            tick_q  <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign level   = level_q;
    assign state   = state_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with BASE_PERIOD=16, LEVELS=4,
// FOODS_PER_LEVEL=2; tick times are measured in edges from a reference edge.
module tb_game_tick_scheduler;

    logic       clk = 1'b0;
    logic       clear_b;
    logic       start;
    logic       pause;
    logic       food_eaten;
    logic       game_over;
`ifdef GAME_TICK_TURBO_EN
    logic       turbo;
`endif
    logic       tick;
    logic [1:0] level;
    logic [1:0] state;
    logic       running;

    int cyc = 0;
    int vectors = 0;
    int errs = 0;
    int t0;
    int at;

    game_tick_scheduler #(
        .CNT_W           (8),
        .BASE_PERIOD     (16),
        .LEVELS          (4),
        .FOODS_PER_LEVEL (2)
    ) dut (
        .clk        (clk),
        .clear_b    (clear_b),
        .start      (start),
        .pause      (pause),
        .food_eaten (food_eaten),
        .game_over  (game_over),
`ifdef GAME_TICK_TURBO_EN
        .turbo      (turbo),
`endif
        .tick       (tick),
        .level      (level),
        .state      (state),
        .running    (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the edge number at which tick was registered high (bounded).
    task automatic wait_tick(input int budget, output int edge_at);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < budget);
        edge_at = cyc;
    endtask

    initial begin
        clear_b    = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        food_eaten = 1'b0;
        game_over  = 1'b0;
`ifdef GAME_TICK_TURBO_EN
        turbo      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_tick", tick, 0);
        check("rst_level", level, 0);
        check("rst_state", state, 0);
        check("rst_running", running, 0);

        clear_b = 1'b1;
        repeat (3) step();
        check("idle_state", state, 0);
        check("idle_tick", tick, 0);

        // Start: ticks every 16 edges after the start edge.
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
        check("start_state", state, 1);
        check("start_running", running, 1);
        check("start_tick", tick, 0);
        wait_tick(40, at); check("s1_tick1", at - t0, 16); t0 = at;
        wait_tick(40, at); check("s1_tick2", at - t0, 16); t0 = at;
        wait_tick(40, at); check("s1_tick3", at - t0, 16); t0 = at;
        check("s1_level", level, 0);

        // Two food pulses: level 1, current interval stays 16, then 8.
        food_eaten = 1'b1;
        step();
        step();
        food_eaten = 1'b0;
        check("s2_level", level, 1);
        wait_tick(40, at); check("s2_tick_old", at - t0, 16); t0 = at;
        wait_tick(40, at); check("s2_tick_new", at - t0, 8); t0 = at;

        // Pause 5 cycles starting at count 7: next tick 13 edges out.
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("s3_paused_state", state, 2);
            check("s3_paused_tick", tick, 0);
        end
        pause = 1'b0;
        step();
        check("s3_resume_state", state, 1);
        wait_tick(40, at); check("s3_tick_late", at - t0, 13); t0 = at;

        // game_over with food on the same edge.
        repeat (3) step();
        game_over  = 1'b1;
        food_eaten = 1'b1;
        step();
        game_over  = 1'b0;
        food_eaten = 1'b0;
        check("s4_state", state, 3);
        check("s4_level", level, 1);
        check("s4_running", running, 0);
        check("s4_tick", tick, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("s4_over_tick", tick, 0);
            check("s4_over_state", state, 3);
        end
        check("s4_level_hold", level, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
        check("s4_restart_level", level, 0);
        check("s4_restart_state", state, 1);
        wait_tick(40, at); check("s4_restart_tick", at - t0, 16); t0 = at;

        // Ten food pulses: level saturates at 3, period becomes 2.
        food_eaten = 1'b1;
        repeat (10) step();
        food_eaten = 1'b0;
        check("s5_level_sat", level, 3);
        wait_tick(40, at); check("s5_tick_old", at - t0, 16); t0 = at;
        wait_tick(40, at); check("s5_tick_p2a", at - t0, 2); t0 = at;
        wait_tick(40, at); check("s5_tick_p2b", at - t0, 2); t0 = at;
`ifdef GAME_TICK_TURBO_EN
        turbo = 1'b1;
        wait_tick(40, at); check("s5_turbo_a", at - t0, 2); t0 = at;
        wait_tick(40, at); check("s5_turbo_b", at - t0, 2); t0 = at;
        turbo = 1'b0;
`endif
        check("s5_tick_high", tick, 1);

        // Reset while tick is high: outputs clear without a clock edge.
        clear_b = 1'b0;
        #1;
        check("s6_rst_tick", tick, 0);
        check("s6_rst_level", level, 0);
        check("s6_rst_state", state, 0);
        check("s6_rst_running", running, 0);
        repeat (2) step();
        clear_b = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            check("s6_idle_tick", tick, 0);
            check("s6_idle_state", state, 0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
        wait_tick(40, at); check("s6_restart_tick", at - t0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
